muu_value_out_arbiter: RTL and testbench



---
 rtl/muu_value_out_arbiter_pkg.sv | 22 ++
 rtl/muu_rr_pick.sv | 41 ++++
 rtl/muu_value_out_arbiter.sv | 169 ++++++++++++++++
 tb/tb_muu_value_out_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muu_value_out_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// muu_value_out_arbiter_pkg
// Shared definitions for the muu response-stream arbiters: FSM state
// encodings, counter/index widths and the {meta,word} data-width helper.
// -----------------------------------------------------------------------------
package muu_value_out_arbiter_pkg;

    // Arbiter FSM encodings (kept as plain constants for legacy tooling)
    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Word counter width inside one emitted packet
    localparam int WCNT_WIDTH  = 10;
    // Width of port indices (covers up to 8 ports)
    localparam int GRANT_WIDTH = 3;

    // Width of one {meta,word} beat
    function automatic int data_width(input int meta_w, input int word_w);
        return meta_w + word_w;
    endfunction

endpackage

// File: rtl/muu_rr_pick.sv
// -----------------------------------------------------------------------------
// muu_rr_pick
// Combinational rotating-priority picker. Searches i_req starting at the port
// after i_last, wrapping modulo NUM_PORTS, and returns the first requester.
// Ports:
//   i_req  [NUM_PORTS] request vector
//   i_last [3]         previously granted index (search starts at i_last+1)
//   o_any  [1]         at least one request present
//   o_idx  [3]         selected index (holds i_last when o_any is low)
// -----------------------------------------------------------------------------
module muu_rr_pick
    import muu_value_out_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]   i_req,
    input  logic [GRANT_WIDTH-1:0] i_last,
    output logic                   o_any,
    output logic [GRANT_WIDTH-1:0] o_idx
);

    localparam int IW = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;

    logic [31:0] w_cand;
    logic        w_hit;

    // First requester in rotated order; later hits are masked by o_any
    always_comb begin
        o_any  = 1'b0;
        o_idx  = i_last;
        w_cand = 32'd0;
        w_hit  = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_cand = 32'((int'(i_last) + k) % NUM_PORTS);
            w_hit  = !o_any && i_req[w_cand[IW-1:0]];
            o_idx  = w_hit ? GRANT_WIDTH'(w_cand) : o_idx;
            o_any  = o_any | w_hit;
        end
    end

endmodule

// File: rtl/muu_value_out_arbiter.sv
// -----------------------------------------------------------------------------
// muu_value_out_arbiter
// Packet-atomic round-robin arbiter sharing one {meta,word} response stream
// between NUM_PORTS value-get engines. Overlong packets are split at
// MAX_WORDS_IN_PACKET words; emitted packets and forced splits are counted.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_data/in_user/in_valid/in_last per-port packet stream (port i at slice i)
//   in_ready                       per-port accept (only the granted port)
//   out_data/out_user/out_valid/out_last registered output beat
//   out_ready                      downstream accept
//   grant_idx                      current / last granted port
//   busy                           high while streaming a packet
//   stat_packets, stat_splits      wrap-around statistics
// -----------------------------------------------------------------------------
module muu_value_out_arbiter
    import muu_value_out_arbiter_pkg::*;
#(
    parameter int NUM_PORTS           = 4,
    parameter int META_WIDTH          = 96,
    parameter int WORD_WIDTH          = 512,
    parameter int USER_WIDTH          = 8,
    parameter int MAX_WORDS_IN_PACKET = 160
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_PORTS*(META_WIDTH+WORD_WIDTH)-1:0] in_data,
    input  logic [NUM_PORTS*USER_WIDTH-1:0]              in_user,
    input  logic [NUM_PORTS-1:0]                         in_valid,
    input  logic [NUM_PORTS-1:0]                         in_last,
    output logic [NUM_PORTS-1:0]                         in_ready,
    output logic [META_WIDTH+WORD_WIDTH-1:0]             out_data,
    output logic [USER_WIDTH-1:0]                        out_user,
    output logic                                         out_valid,
    output logic                                         out_last,
    input  logic                                         out_ready,
    output logic [GRANT_WIDTH-1:0]                       grant_idx,
    output logic                                         busy,
    output logic [31:0]                                  stat_packets,
    output logic [31:0]                                  stat_splits
);

    localparam int DW = data_width(META_WIDTH, WORD_WIDTH);

    logic [0:0]             r_state;
    logic [GRANT_WIDTH-1:0] r_grant;
    logic [WCNT_WIDTH-1:0]  r_wcnt;
    logic [DW-1:0]          r_out_data;
    logic [USER_WIDTH-1:0]  r_out_user;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic [31:0]            r_stat_packets;
    logic [31:0]            r_stat_splits;

    logic                   w_can_load;
    logic                   w_xfer;
    logic                   w_cap;
    logic                   w_sel_valid;
    logic                   w_sel_last;
    logic [DW-1:0]          w_sel_data;
    logic [USER_WIDTH-1:0]  w_sel_user;
    logic                   w_pick_any;
    logic [GRANT_WIDTH-1:0] w_pick_idx;

    muu_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .i_req  (in_valid),
        .i_last (r_grant),
        .o_any  (w_pick_any),
        .o_idx  (w_pick_idx)
    );

    // Mux the granted port's stream; other ports are never looked at
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_user  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_sel_valid = (r_grant == GRANT_WIDTH'(p)) ? in_valid[p] : w_sel_valid;
            w_sel_last  = (r_grant == GRANT_WIDTH'(p)) ? in_last[p]  : w_sel_last;
            w_sel_data  = (r_grant == GRANT_WIDTH'(p)) ? in_data[p*DW +: DW] : w_sel_data;
            w_sel_user  = (r_grant == GRANT_WIDTH'(p)) ? in_user[p*USER_WIDTH +: USER_WIDTH] : w_sel_user;
        end
    end

    // Output register may take a new beat when empty or draining this cycle
    assign w_can_load = !r_out_valid || out_ready;
    assign w_xfer     = (r_state == ST_STREAM) && w_sel_valid && w_can_load;
    assign w_cap      = (r_wcnt == 10'(MAX_WORDS_IN_PACKET - 1));

    // Ready goes only to the granted port, gated by output-register space
    always_comb begin
        in_ready = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            in_ready[p] = (r_state == ST_STREAM) && (r_grant == GRANT_WIDTH'(p)) && w_can_load;
        end
    end

    // Single-entry output stage; contents hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_out_data     <= '0;
            r_out_user     <= '0;
            r_stat_packets <= 32'd0;
        end else begin
            if (w_can_load) begin
                r_out_valid <= w_xfer;
            end
            if (w_xfer) begin
                r_out_data <= w_sel_data;
                r_out_user <= w_sel_user;
                r_out_last <= w_sel_last || w_cap;
            end
            if (r_out_valid && out_ready && r_out_last) begin
                r_stat_packets <= r_stat_packets + 32'd1;
            end
        end
    end

    // Arbitration / streaming FSM with packet-length cap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_ARB;
            r_grant       <= GRANT_WIDTH'(NUM_PORTS - 1);
            r_wcnt        <= 10'd0;
            r_stat_splits <= 32'd0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_pick_any) begin
                        r_grant <= w_pick_idx;
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        if (w_sel_last) begin
                            r_wcnt  <= 10'd0;
                            r_state <= ST_ARB;
                        end else if (w_cap) begin
                            // Forced last: remainder continues on the same port
                            r_wcnt        <= 10'd0;
                            r_stat_splits <= r_stat_splits + 32'd1;
                        end else begin
                            r_wcnt <= r_wcnt + 10'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

    assign out_data     = r_out_data;
    assign out_user     = r_out_user;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_last;
    assign grant_idx    = r_grant;
    assign busy         = (r_state == ST_STREAM);
    assign stat_packets = r_stat_packets;
    assign stat_splits  = r_stat_splits;

endmodule

// File: tb/tb_muu_value_out_arbiter.sv
module tb_muu_value_out_arbiter;

    localparam int NP   = 4;
    localparam int MW   = 96;
    localparam int WW   = 512;
    localparam int UW   = 8;
    localparam int MAXW = 4;
    localparam int DW   = MW + WW;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP*DW-1:0]  in_data = '0;
    logic [NP*UW-1:0]  in_user = '0;
    logic [NP-1:0]     in_valid = '0;
    logic [NP-1:0]     in_last = '0;
    logic [NP-1:0]     in_ready;
    logic [DW-1:0]     out_data;
    logic [UW-1:0]     out_user;
    logic              out_valid;
    logic              out_last;
    logic              out_ready = 1'b1;
    logic [2:0]        grant_idx;
    logic              busy;
    logic [31:0]       stat_packets;
    logic [31:0]       stat_splits;

    muu_value_out_arbiter #(
        .NUM_PORTS(NP), .META_WIDTH(MW), .WORD_WIDTH(WW),
        .USER_WIDTH(UW), .MAX_WORDS_IN_PACKET(MAXW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_user(in_user), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_user(out_user), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready),
        .grant_idx(grant_idx), .busy(busy),
        .stat_packets(stat_packets), .stat_splits(stat_splits)
    );

    always #5 clk = ~clk;

    // reference model state
    word_t         q[NP][$];
    exp_t          eq[$];
    int            order[$];
    logic [UW-1:0] tag[NP];
    logic [NP-1:0] en = '1;
    int            rmode = 0;
    int            rand_en = 0;
    int            cyc = 0;
    int            seq = 0;
    int            mcnt = 0;
    bit            mid_pkt = 0;
    int            cur_port = 0;
    int            exp_packets = 0;
    int            exp_splits = 0;
    int            n_acc = 0;
    int            n_out = 0;
    int            last_acc_cyc = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] held_data;
    logic [UW-1:0] held_user;
    logic          held_last;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    task automatic add_pkt(input int p, input int len);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.data = '0;
            w.data[31:0] = $urandom;
            w.data[63:32] = 32'(seq);
            w.data[DW-1 -: 8] = 8'(p);
            w.last = (i == len - 1);
            q[p].push_back(w);
            seq++;
        end
    endtask

    task automatic drive();
        case (rmode)
            1: out_ready = (cyc % 2 == 0);
            2: out_ready = ($urandom_range(0, 9) < 7);
            default: out_ready = 1'b1;
        endcase
        for (int p = 0; p < NP; p++) begin
            if (rand_en != 0) en[p] = ($urandom_range(0, 3) != 0);
            else en[p] = 1'b1;
            in_valid[p] = en[p] && (q[p].size() > 0);
            in_user[p*UW +: UW] = tag[p];
            if (q[p].size() > 0) begin
                in_data[p*DW +: DW] = q[p][0].data;
                in_last[p] = q[p][0].last;
            end else begin
                in_data[p*DW +: DW] = {(DW/32){32'hDEADBEEF}};
                in_last[p] = 1'b1;
            end
        end
    endtask

    task automatic observe();
        word_t w;
        exp_t  e;
        if (rst) return;
        if (prev_stall) begin
            chk("hold_data", out_data, held_data);
            chk("hold_user", DW'(out_user), DW'(held_user));
            chk("hold_last", DW'(out_last), DW'(held_last));
        end
        chk("ready_onehot", DW'($countones(in_ready) <= 1), DW'(1));
        if (out_valid && !out_ready) chk("ready_stalled", DW'(in_ready), DW'(0));
        for (int p = 0; p < NP; p++) begin
            if (in_valid[p] && in_ready[p]) begin
                w = q[p].pop_front();
                if (mid_pkt) chk("atomic_port", DW'(p), DW'(cur_port));
                else order.push_back(p);
                e.data = w.data;
                e.user = tag[p];
                e.last = w.last || (mcnt == MAXW - 1);
                eq.push_back(e);
                if (e.last) begin
                    if (!w.last) exp_splits++;
                    mcnt = 0;
                    mid_pkt = 0;
                end else begin
                    mcnt++;
                    mid_pkt = 1;
                    cur_port = p;
                end
                n_acc++;
                last_acc_cyc = cyc;
            end
        end
        if (out_valid && out_ready) begin
            n_out++;
            if (eq.size() == 0) begin
                chk("unexpected_out", DW'(1), DW'(0));
            end else begin
                e = eq.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_user", DW'(out_user), DW'(e.user));
                chk("out_last", DW'(out_last), DW'(e.last));
                if (e.last) exp_packets++;
            end
        end
        prev_stall = out_valid && !out_ready;
        held_data = out_data;
        held_user = out_user;
        held_last = out_last;
        cyc++;
    endtask

    task automatic tick();
        drive();
        #1;
        observe();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit idle();
        bit r = (eq.size() == 0) && !out_valid;
        for (int p = 0; p < NP; p++) if (q[p].size() != 0) r = 0;
        return r;
    endfunction

    task automatic drain(input int max);
        int n = 0;
        while (!idle() && n < max) begin
            tick();
            n++;
        end
        chk("drain_timeout", DW'(idle()), DW'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int p = 0; p < NP; p++) q[p].delete();
        eq.delete();
        order.delete();
        mcnt = 0; mid_pkt = 0; exp_packets = 0; exp_splits = 0; prev_stall = 0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int c0, o0, n0, idx, base_acc, lim;
        for (int p = 0; p < NP; p++) tag[p] = 8'(p * 16 + $urandom_range(0, 15));
        do_reset();
        tick();

        // reset state
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_out_last", DW'(out_last), DW'(0));
        chk("rst_in_ready", DW'(in_ready), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_grant", DW'(grant_idx), DW'(NP - 1));
        chk("rst_pkts", DW'(stat_packets), DW'(0));
        chk("rst_splits", DW'(stat_splits), DW'(0));

        // single 3-word packet on port 2
        add_pkt(2, 3);
        tick();
        chk("sp_grant", DW'(grant_idx), DW'(2));
        chk("sp_busy", DW'(busy), DW'(1));
        chk("sp_ready", DW'(in_ready), DW'(4'b0100));
        chk("sp_valid_t1", DW'(out_valid), DW'(0));
        tick();
        chk("sp_valid_t2", DW'(out_valid), DW'(1));
        chk("sp_user", DW'(out_user), DW'(tag[2]));
        tick(); tick(); tick();
        chk("sp_nout", DW'(n_out), DW'(3));
        drain(50);
        chk("sp_pkts", DW'(stat_packets), DW'(1));

        // round robin 0,1,3 after reset
        do_reset();
        add_pkt(0, 2); add_pkt(1, 2); add_pkt(3, 2);
        c0 = cyc;
        drain(100);
        chk("rr_count", DW'(order.size()), DW'(3));
        chk("rr_first", DW'(order[0]), DW'(0));
        chk("rr_second", DW'(order[1]), DW'(1));
        chk("rr_third", DW'(order[2]), DW'(3));
        chk("rr_timing", DW'(last_acc_cyc - c0), DW'(8));
        chk("rr_pkts", DW'(stat_packets), DW'(3));

        // backpressure 1010 on a 5-word packet (cap splits after 4)
        rmode = 1;
        add_pkt(0, 5);
        drain(100);
        rmode = 0;
        chk("bp_pkts", DW'(stat_packets), DW'(5));
        chk("bp_splits", DW'(stat_splits), DW'(1));

        // cap: 10 words on port 1 with port 3 waiting
        o0 = order.size();
        add_pkt(1, 10);
        add_pkt(3, 1);
        drain(100);
        chk("cap_count", DW'(order.size() - o0), DW'(4));
        chk("cap_o0", DW'(order[o0]), DW'(1));
        chk("cap_o1", DW'(order[o0 + 1]), DW'(1));
        chk("cap_o2", DW'(order[o0 + 2]), DW'(1));
        chk("cap_o3", DW'(order[o0 + 3]), DW'(3));
        chk("cap_splits", DW'(stat_splits), DW'(3));
        chk("cap_pkts", DW'(stat_packets), DW'(9));
        chk("cap_model_splits", DW'(stat_splits), DW'(exp_splits));

        // reset after word 2 of a 6-word packet
        add_pkt(2, 6);
        base_acc = n_acc;
        lim = 0;
        while (n_acc < base_acc + 2 && lim < 20) begin
            tick();
            lim++;
        end
        chk("mr_reach", DW'(n_acc - base_acc), DW'(2));
        do_reset();
        chk("mr_out_valid", DW'(out_valid), DW'(0));
        chk("mr_in_ready", DW'(in_ready), DW'(0));
        chk("mr_busy", DW'(busy), DW'(0));
        chk("mr_pkts", DW'(stat_packets), DW'(0));
        chk("mr_splits", DW'(stat_splits), DW'(0));
        add_pkt(2, 1);
        add_pkt(0, 1);
        drain(50);
        chk("mr_first", DW'(order[0]), DW'(0));
        chk("mr_second", DW'(order[1]), DW'(2));

        // fairness: port 0 streams 1-word packets, port 2 joins
        for (int i = 0; i < 8; i++) add_pkt(0, 1);
        for (int i = 0; i < 5; i++) tick();
        n0 = order.size();
        add_pkt(2, 1);
        drain(100);
        idx = -1;
        for (int i = n0; i < order.size(); i++) if (idx < 0 && order[i] == 2) idx = i;
        chk("fair_found", DW'(idx >= 0), DW'(1));
        chk("fair_next", DW'((idx >= n0) && (idx <= n0 + 1)), DW'(1));

        // randomized traffic with random backpressure and valid gaps
        rmode = 2;
        rand_en = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                int p;
                p = $urandom_range(0, NP - 1);
                if (q[p].size() < 12) add_pkt(p, $urandom_range(1, 9));
            end
            tick();
        end
        rmode = 0;
        rand_en = 0;
        drain(3000);
        chk("rand_pkts", DW'(stat_packets), DW'(exp_packets));
        chk("rand_splits", DW'(stat_splits), DW'(exp_splits));
        chk("rand_busy", DW'(busy), DW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
